// File: rtl/des_rounds.sv
// Iterative DES round engine: 16 Feistel rounds, one per clock, with on-the-fly key schedule.
// Optional DES_ROUNDS_PARITY_CHK_EN adds key_err and rejects keys whose bytes lack odd parity.

// Combinational DES f-function: E expansion, key mix, S-boxes, P permutation.
module des_f (
    input  logic [31:0] r_i,
    input  logic [47:0] k_i,
    output logic [31:0] f_c
);
    localparam int unsigned RW = 32;
    localparam int unsigned EW = 48;

    localparam logic [0:47][5:0] E_T = {
        6'd32, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5,
        6'd4,  6'd5,  6'd6,  6'd7,  6'd8,  6'd9,
        6'd8,  6'd9,  6'd10, 6'd11, 6'd12, 6'd13,
        6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17,
        6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
        6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25,
        6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
        6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd1
    };

    localparam logic [0:31][5:0] P_T = {
        6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
        6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
        6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
        6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
    };

    // S1..S8, each 4 rows of 16 nibbles; entry (row*16+col) sits 4*entry bits below the box top.
    localparam logic [2047:0] SBOX = {
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    logic [EW-1:0] e_c;
    logic [EW-1:0] x_c;
    logic [RW-1:0] s_c;
    logic [5:0]    six_c;
    logic [5:0]    idx_c;

    // Internal vectors keep DES bit 1 at the MSB.
    always_comb begin
        e_c   = '0;
        s_c   = '0;
        six_c = '0;
        idx_c = '0;
        f_c   = '0;
        for (int i = 0; i < 48; i++) begin
            e_c[6'(47 - i)] = r_i[5'(32 - int'(E_T[6'(i)]))];
        end
        x_c = e_c ^ k_i;
        for (int b = 0; b < 8; b++) begin
            six_c = x_c[6'(47 - 6 * b) -: 6];
            idx_c = {six_c[5], six_c[0], six_c[4:1]};
            s_c[5'(31 - 4 * b) -: 4] = SBOX[11'(2047 - 256 * b - 4 * int'(idx_c)) -: 4];
        end
        for (int i = 0; i < 32; i++) begin
            f_c[5'(31 - i)] = s_c[5'(32 - int'(P_T[5'(i)]))];
        end
    end
endmodule

module des_rounds (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [1:64] din,
    input  logic [1:64] key,
    output logic        busy,
    output logic        done,
    output logic [1:64] dout
`ifdef DES_ROUNDS_PARITY_CHK_EN
    ,
    output logic        key_err
`endif
);
    localparam int unsigned BW  = 64;
    localparam int unsigned HW  = 32;
    localparam int unsigned CW  = 28;
    localparam int unsigned KW  = 48;
    localparam int unsigned RNW = 5;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [0:55][5:0] PC1_T = {
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
        6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
        6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
        6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
        6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
        6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
        6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    localparam logic [0:47][5:0] PC2_T = {
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    function automatic logic [55:0] pc1(input logic [BW-1:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[6'(55 - i)] = k[6'(64 - int'(PC1_T[6'(i)]))];
        end
        return r;
    endfunction

    function automatic logic [KW-1:0] pc2(input logic [55:0] cd);
        logic [KW-1:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[6'(47 - i)] = cd[6'(56 - int'(PC2_T[6'(i)]))];
        end
        return r;
    endfunction

    // Decrypt walks the schedule backwards, so rotations run right instead of left.
    function automatic logic [CW-1:0] rot28(input logic [CW-1:0] x, input logic dec,
                                            input logic [1:0] amt);
        logic [CW-1:0] r;
        r = x;
        case (amt)
            2'd1:    r = dec ? {x[0], x[27:1]}   : {x[26:0], x[27]};
            2'd2:    r = dec ? {x[1:0], x[27:2]} : {x[25:0], x[27:26]};
            default: r = x;
        endcase
        return r;
    endfunction

    logic [0:0]     state_q, state_d;
    logic [RNW-1:0] rnd_q, rnd_d;
    logic [HW-1:0]  l_q, l_d, r_q, r_d;
    logic [CW-1:0]  c_q, c_d, d_q, d_d;
    logic           dec_q, dec_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [BW-1:0]  dout_q, dout_d;
    logic           key_err_q, key_err_d;

    logic [BW-1:0]  din_c;
    logic [BW-1:0]  key_c;
    logic           one_step_c;
    logic [1:0]     amt_c;
    logic [CW-1:0]  c_rot_c, d_rot_c;
    logic [KW-1:0]  rkey_c;
    logic [HW-1:0]  f_c;
    logic [HW-1:0]  r_new_c;
    logic           key_ok_c;

    assign din_c = din;
    assign key_c = key;

    // Rounds 1, 2, 9, 16 shift by one; decrypt round 1 reuses C0||D0 unrotated for K16.
    always_comb begin
        one_step_c = (rnd_q == 5'd1) || (rnd_q == 5'd2) || (rnd_q == 5'd9) || (rnd_q == 5'd16);
        amt_c      = one_step_c ? 2'd1 : 2'd2;
        if (dec_q && (rnd_q == 5'd1)) begin
            amt_c = 2'd0;
        end
    end

    assign c_rot_c = rot28(c_q, dec_q, amt_c);
    assign d_rot_c = rot28(d_q, dec_q, amt_c);
    assign rkey_c  = pc2({c_rot_c, d_rot_c});

    des_f u_f (
        .r_i (r_q),
        .k_i (rkey_c),
        .f_c (f_c)
    );

    assign r_new_c = l_q ^ f_c;

`ifdef DES_ROUNDS_PARITY_CHK_EN
    always_comb begin
        key_ok_c = 1'b1;
        for (int b = 0; b < 8; b++) begin
            key_ok_c = key_ok_c & (^key_c[6'(63 - 8 * b) -: 8]);
        end
    end
`else
    assign key_ok_c = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        rnd_d     = rnd_q;
        l_d       = l_q;
        r_d       = r_q;
        c_d       = c_q;
        d_d       = d_q;
        dec_d     = dec_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dout_d    = dout_q;
        key_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    if (key_ok_c) begin
                        l_d        = din_c[63:32];
                        r_d        = din_c[31:0];
                        {c_d, d_d} = pc1(key_c);
                        dec_d      = decrypt;
                        rnd_d      = 5'd1;
                        busy_d     = 1'b1;
                        state_d    = RUN;
                    end else begin
                        key_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                c_d = c_rot_c;
                d_d = d_rot_c;
                l_d = r_q;
                r_d = r_new_c;
                if (rnd_q == 5'd16) begin
                    dout_d  = {r_new_c, r_q};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    rnd_d   = '0;
                    state_d = IDLE;
                end else begin
                    rnd_d = rnd_q + 5'd1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rnd_q     <= '0;
            l_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            dec_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dout_q    <= '0;
            key_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rnd_q     <= rnd_d;
            l_q       <= l_d;
            r_q       <= r_d;
            c_q       <= c_d;
            d_q       <= d_d;
            dec_q     <= dec_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dout_q    <= dout_d;
            key_err_q <= key_err_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;

`ifdef DES_ROUNDS_PARITY_CHK_EN
    assign key_err = key_err_q;
`endif
endmodule

// File: tb/tb_des_rounds.sv
// Directed bench for des_rounds: known DES vectors, busy/back-to-back timing, reset abort,
// and key parity rejection when DES_ROUNDS_PARITY_CHK_EN is defined.
module tb_des_rounds;
    localparam logic [63:0] KEY_GOOD = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_BAD  = 64'h123457799BBCDFF1;
    localparam logic [63:0] PT_IP    = 64'hCC00CCFFF0AAF0AA;
    localparam logic [63:0] CT_PRE   = 64'h0A4CD99543423234;
    // Ticks from the start-setup cycle to the done cycle: acceptance edge plus 16 rounds.
    localparam int TICKS_TO_DONE = 17;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        decrypt;
    logic [1:64] din;
    logic [1:64] key;
    logic        busy;
    logic        done;
    logic [1:64] dout;
`ifdef DES_ROUNDS_PARITY_CHK_EN
    logic        key_err;
`endif

    int n_cmp  = 0;
    int n_err  = 0;
    int n_done = 0;
    logic [63:0] exp_q[$];

    des_rounds dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .decrypt (decrypt),
        .din     (din),
        .key     (key),
        .busy    (busy),
        .done    (done),
        .dout    (dout)
`ifdef DES_ROUNDS_PARITY_CHK_EN
        ,
        .key_err (key_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic dec, input logic [63:0] d, input logic [63:0] k);
        start   = 1'b1;
        decrypt = dec;
        din     = d;
        key     = k;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            start = 1'b0;
            cyc++;
            if (done === 1'b1) break;
        end
    endtask

    // Scoreboard: every done pops one expected preoutput.
    initial begin
        forever begin
            tick();
            if (done === 1'b1) begin
                n_done++;
                n_cmp++;
                assert (exp_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_done: observed dout %h expected no done", dout);
                end
                if (exp_q.size() != 0) chk("dout", 64'(dout), exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int done_base;

        rst = 1'b1; start = 1'b0; decrypt = 1'b0; din = '0; key = '0;
        tick(); tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
`ifdef DES_ROUNDS_PARITY_CHK_EN
        chk("rst_key_err", 64'(key_err), 64'd0);
`endif
        rst = 1'b0;
        tick();

        // Encrypt known vector.
        drive(1'b0, PT_IP, KEY_GOOD);
        exp_q.push_back(CT_PRE);
        tick();
        start = 1'b0;
        chk("enc_busy_run", 64'(busy), 64'd1);
        wait_done(cyc);
        chk("enc_latency", 64'(cyc + 1), 64'(TICKS_TO_DONE));
        chk("enc_busy_at_done", 64'(busy), 64'd0);
        tick();
        chk("enc_done_one_cycle", 64'(done), 64'd0);
        chk("enc_dout_hold", 64'(dout), CT_PRE);

        // Decrypt back to the plaintext.
        drive(1'b1, CT_PRE, KEY_GOOD);
        exp_q.push_back(PT_IP);
        wait_done(cyc);
        chk("dec_latency", 64'(cyc), 64'(TICKS_TO_DONE));

        // Starts during RUN are ignored.
        tick();
        done_base = n_done;
        drive(1'b0, PT_IP, KEY_GOOD);
        exp_q.push_back(CT_PRE);
        tick();
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 3 || i == 9) drive(1'b1, 64'hDEADBEEF01234567, 64'h0123456789ABCDEF);
            else start = 1'b0;
            if (i == 5) chk("busy_mid_run", 64'(busy), 64'd1);
            if (i == 8) chk("dout_stable_in_run", 64'(dout), PT_IP);
            tick();
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
        start = 1'b0;
        chk("busy_test_latency", 64'(cyc), 64'd16);
        repeat (20) tick();
        chk("busy_test_done_count", 64'(n_done - done_base), 64'd1);

        // Back-to-back: start during the done cycle.
        drive(1'b0, PT_IP, KEY_GOOD);
        exp_q.push_back(CT_PRE);
        wait_done(cyc);
        chk("b2b_first_latency", 64'(cyc), 64'(TICKS_TO_DONE));
        drive(1'b1, CT_PRE, KEY_GOOD);
        exp_q.push_back(PT_IP);
        wait_done(cyc);
        chk("b2b_gap", 64'(cyc), 64'd17);

        // Reset during round 8 aborts the block.
        tick();
        done_base = n_done;
        drive(1'b0, PT_IP, KEY_GOOD);
        tick();
        start = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_dout", 64'(dout), 64'd0);
        rst = 1'b0;
        repeat (25) tick();
        chk("abort_no_done", 64'(n_done - done_base), 64'd0);
        drive(1'b0, PT_IP, KEY_GOOD);
        exp_q.push_back(CT_PRE);
        wait_done(cyc);
        chk("post_abort_latency", 64'(cyc), 64'(TICKS_TO_DONE));

`ifdef DES_ROUNDS_PARITY_CHK_EN
        tick();
        done_base = n_done;
        drive(1'b0, PT_IP, KEY_BAD);
        tick();
        start = 1'b0;
        chk("par_key_err_pulse", 64'(key_err), 64'd1);
        chk("par_busy", 64'(busy), 64'd0);
        tick();
        chk("par_key_err_clear", 64'(key_err), 64'd0);
        repeat (20) tick();
        chk("par_no_done", 64'(n_done - done_base), 64'd0);
        chk("par_dout_unchanged", 64'(dout), CT_PRE);
        drive(1'b0, PT_IP, KEY_GOOD);
        exp_q.push_back(CT_PRE);
        tick();
        start = 1'b0;
        chk("par_good_no_err", 64'(key_err), 64'd0);
        chk("par_good_busy", 64'(busy), 64'd1);
        wait_done(cyc);
        chk("par_good_latency", 64'(cyc), 64'd16);
`endif

        repeat (3) tick();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef DES_ROUNDS_PARITY_CHK_EN
        chk("total_dones", 64'(n_done), 64'd7);
`else
        chk("total_dones", 64'(n_done), 64'd6);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
